// File: rtl/hs_valid_initiator_chk.sv
// hs_valid_initiator_chk
// Link-side properties of the initiator, bound into every hs_valid_initiator:
// ready must be seen within MAX_WAIT valid cycles or a timeout must follow,
// and data must not move while valid waits for ready.

module hs_valid_initiator_chk #(
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 5
) (
  input logic              clk,
  input logic              rst,
  input logic              valid,
  input logic              ready,
  input logic [DATA_W-1:0] data,
  input logic              timeout
);

  localparam int RW = $clog2(MAX_WAIT + 1);
  localparam logic [RW-1:0] LAST = RW'(MAX_WAIT - 1);

  logic [RW-1:0] run_r;

  // Count the valid cycles of the current attempt that have not seen ready.
  always_ff @(posedge clk) begin
    if (!rst || !valid || ready) begin
      run_r <= {RW{1'b0}};
    end else if (run_r != {RW{1'b1}}) begin
      run_r <= run_r + {{(RW-1){1'b0}}, 1'b1};
    end else begin
      run_r <= run_r;
    end
  end

  a_window : assert property (@(posedge clk) disable iff (!rst)
    valid |-> (run_r <= LAST));

  a_timeout : assert property (@(posedge clk) disable iff (!rst)
    (valid && !ready && (run_r == LAST)) |=> timeout);

  a_stable : assert property (@(posedge clk) disable iff (!rst)
    (valid && !ready) |=> (!valid || $stable(data)));

endmodule

bind hs_valid_initiator hs_valid_initiator_chk #(
  .DATA_W   (DATA_W),
  .MAX_WAIT (MAX_WAIT)
) u_chk (
  .clk     (clk),
  .rst     (rst),
  .valid   (valid),
  .ready   (ready),
  .data    (data),
  .timeout (timeout)
);

// File: rtl/hs_valid_initiator.sv
// hs_valid_initiator
// Source end of a valid/ready link. A word taken from the local producer is
// driven on valid/data and held until the responder answers with ready. If
// ready is missing for the whole response window, the word is re-sent after a
// one-cycle gap. Once the re-send budget is used up, the word is dropped with
// an abort pulse. All outputs come straight from registers.

module hs_valid_initiator #(
  parameter  int DATA_W    = 8,
  parameter  int MAX_WAIT  = 5,
  parameter  int MAX_RETRY = 2,
  localparam int RCW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  input  logic              ready,
  output logic              done,
  output logic              timeout,
  output logic              abort,
  output logic [RCW-1:0]    retry_cnt,
  output logic              busy
);

  // The wait counter must hold 0..MAX_WAIT-1; the +1 keeps it at least one
  // bit wide when MAX_WAIT is 1.
  localparam int WCW = $clog2(MAX_WAIT + 1);

  localparam logic [WCW-1:0] LAST_WAIT = WCW'(MAX_WAIT - 1);
  localparam logic [RCW-1:0] RETRY_LIM = RCW'(MAX_RETRY);

  // The unused encoding 2'd3 is caught by the default branch and steered back
  // to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] data_s;
  logic [WCW-1:0]    wait_cnt_r;
  logic [WCW-1:0]    wait_cnt_s;
  logic [RCW-1:0]    retry_cnt_r;
  logic [RCW-1:0]    retry_cnt_s;
  logic              done_r;
  logic              done_s;
  logic              timeout_r;
  logic              timeout_s;
  logic              abort_r;
  logic              abort_s;
  logic              valid_r;
  logic              req_ready_r;
  logic              busy_r;

  // Next-state and next-pulse decode for the accept / send / gap sequence.
  always_comb begin
    state_s     = state_r;
    data_s      = data_r;
    wait_cnt_s  = wait_cnt_r;
    retry_cnt_s = retry_cnt_r;
    done_s      = 1'b0;
    timeout_s   = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          data_s      = req_data;
          wait_cnt_s  = {WCW{1'b0}};
          retry_cnt_s = {RCW{1'b0}};
          state_s     = ST_SEND;
        end else begin
          state_s     = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (ready) begin
          // Handshake at this edge. The next cycle is IDLE, so two words are
          // never sent back to back.
          done_s     = 1'b1;
          wait_cnt_s = {WCW{1'b0}};
          state_s    = ST_IDLE;
        end else if (wait_cnt_r < LAST_WAIT) begin
          wait_cnt_s = wait_cnt_r + {{(WCW-1){1'b0}}, 1'b1};
        end else begin
          // The last window cycle passed without ready.
          timeout_s  = 1'b1;
          wait_cnt_s = {WCW{1'b0}};
          if (retry_cnt_r < RETRY_LIM) begin
            retry_cnt_s = retry_cnt_r + {{(RCW-1){1'b0}}, 1'b1};
            state_s     = ST_GAP;
          end else begin
            // retry_cnt keeps its final value until the next word is taken.
            abort_s     = 1'b1;
            state_s     = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        // One cycle with valid low. ready is ignored here; data is kept for
        // the re-send.
        wait_cnt_s = {WCW{1'b0}};
        state_s    = ST_SEND;
      end
      default: begin
        wait_cnt_s  = {WCW{1'b0}};
        retry_cnt_s = {RCW{1'b0}};
        state_s     = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs. Reset takes priority over every other
  // event and discards any word in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      data_r      <= {DATA_W{1'b0}};
      wait_cnt_r  <= {WCW{1'b0}};
      retry_cnt_r <= {RCW{1'b0}};
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
      abort_r     <= 1'b0;
      valid_r     <= 1'b0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      data_r      <= data_s;
      wait_cnt_r  <= wait_cnt_s;
      retry_cnt_r <= retry_cnt_s;
      done_r      <= done_s;
      timeout_r   <= timeout_s;
      abort_r     <= abort_s;
      valid_r     <= (state_s == ST_SEND);
      req_ready_r <= (state_s == ST_IDLE);
      busy_r      <= (state_s != ST_IDLE);
    end
  end

  assign req_ready = req_ready_r;
  assign valid     = valid_r;
  assign data      = data_r;
  assign done      = done_r;
  assign timeout   = timeout_r;
  assign abort     = abort_r;
  assign retry_cnt = retry_cnt_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_hs_valid_initiator.sv
// tb_hs_valid_initiator
// The producer issues words. For each word, a per-attempt ready plan is
// chosen, and the expected outcome is computed from the plan and pushed into
// a scoreboard. The outcome records done or abort, the number of timeouts and
// the total number of valid cycles. A responder process answers valid
// according to the plan. A monitor process checks the link cycle by cycle and
// pops the scoreboard at every done or abort.

module tb_hs_valid_initiator;

  localparam int DATA_W    = 8;
  localparam int MAX_WAIT  = 5;
  localparam int MAX_RETRY = 2;
  localparam int RCW       = 2;

  // Plan: nibble a is the valid-cycle index of attempt a at which ready is
  // raised; any value >= MAX_WAIT means ready never comes in that attempt.
  typedef struct packed {
    logic [7:0] data;
    logic       ab;
    logic [3:0] nto;
    logic [7:0] nv;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic [DATA_W-1:0] req_data = 8'h00;
  logic              req_ready;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready = 1'b0;
  logic              done;
  logic              timeout;
  logic              abort;
  logic [RCW-1:0]    retry_cnt;
  logic              busy;

  exp_t        exp_q[$];
  logic [11:0] plan_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  hs_valid_initiator #(
    .DATA_W    (DATA_W),
    .MAX_WAIT  (MAX_WAIT),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .valid     (valid),
    .data      (data),
    .ready     (ready),
    .done      (done),
    .timeout   (timeout),
    .abort     (abort),
    .retry_cnt (retry_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference outcome: walk the attempts; the first attempt whose ready index
  // lies inside the window completes after index+1 valid cycles. Every
  // attempt before it costs a full window and one timeout.
  function automatic exp_t model(input logic [7:0] d, input logic [11:0] plan);
    exp_t e;
    int   nv;
    int   nto;
    int   r;
    bit   hit;
    nv  = 0;
    nto = 0;
    hit = 1'b0;
    for (int a = 0; a <= MAX_RETRY; a++) begin
      r = int'(plan[4*a +: 4]);
      if (!hit) begin
        if (r < MAX_WAIT) begin
          nv  = nv + r + 1;
          hit = 1'b1;
        end else begin
          nv  = nv + MAX_WAIT;
          nto = nto + 1;
        end
      end
    end
    e.data = d;
    e.ab   = !hit;
    e.nto  = 4'(nto);
    e.nv   = 8'(nv);
    return e;
  endfunction

  // Offer a word. While the DUT is busy, req_valid and req_data are toggled
  // randomly; the DUT must ignore them.
  task automatic send_word(input logic [7:0] d, input logic [11:0] plan);
    int budget;
    budget = 0;
    while (!req_ready && budget < 200) begin
      req_valid = 1'($urandom_range(0, 1));
      req_data  = 8'($urandom);
      @(posedge clk); #1;
      budget++;
    end
    req_valid = 1'b0;
    if (!req_ready) begin
      check("req_ready_wait", 32'(req_ready), 32'd1);
      return;
    end
    exp_q.push_back(model(d, plan));
    plan_q.push_back(plan);
    req_valid = 1'b1;
    req_data  = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data  = 8'($urandom);
    check("accept_latency", 32'({valid, busy, req_ready}), 32'b110);
  endtask

  // Producer: directed scenarios first, then random words.
  initial begin
    logic [11:0] p;
    int          r;
    int          budget;
    rst       = 1'b0;
    req_valid = 1'b1;
    req_data  = 8'hA5;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    send_word(8'hA5, 12'hFF0);
    send_word(8'h3C, 12'hFF0);
    send_word(8'h11, 12'hFF4);
    send_word(8'h22, 12'hF2F);
    send_word(8'h99, 12'hFFF);
    send_word(8'h5A, 12'hFF1);
    // Reset arrives during the third valid cycle of 0x77.
    send_word(8'h77, 12'hFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    plan_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    send_word(8'h78, 12'hFF2);
    for (int i = 0; i < 40; i++) begin
      p = 12'h000;
      for (int a = 0; a < 3; a++) begin
        r = int'($urandom_range(0, 7));
        p[4*a +: 4] = (r >= MAX_WAIT) ? 4'hF : 4'(r);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send_word(8'($urandom), p);
    end
    budget = 0;
    while (exp_q.size() != 0 && budget < 300) begin
      @(posedge clk); #1;
      budget++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Responder: follow the plan of the current word, attempt by attempt.
  // While valid is low, drive random ready, which must have no effect.
  initial begin
    logic [11:0] cur;
    int          att;
    int          k;
    bit          active;
    bit          pv;
    cur    = 12'hFFF;
    att    = 0;
    k      = 0;
    active = 1'b0;
    pv     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        active = 1'b0;
        pv     = 1'b0;
        ready  = 1'b0;
      end else if (valid) begin
        if (!active) begin
          cur    = (plan_q.size() > 0) ? plan_q.pop_front() : 12'hFFF;
          active = 1'b1;
          att    = 0;
          k      = 0;
        end else if (!pv) begin
          att = att + 1;
          k   = 0;
        end else begin
          k = k + 1;
        end
        ready = (att <= MAX_RETRY) && (int'(cur[4*att +: 4]) == k);
        pv    = 1'b1;
      end else begin
        if (done || abort) begin
          active = 1'b0;
        end
        pv    = 1'b0;
        ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: check reset state, data and retry_cnt while valid, pulse rules
  // and the one-cycle gap. At every done or abort, compare against the
  // scoreboard.
  initial begin
    bit   rst_prev;
    bit   gap_exp;
    int   nv;
    int   nto;
    exp_t e;
    rst_prev = 1'b0;
    gap_exp  = 1'b0;
    nv       = 0;
    nto      = 0;
    forever begin
      @(negedge clk);
      if (!rst_prev) begin
        check("reset_state",
              32'({valid, done, timeout, abort, req_ready, busy, retry_cnt, data}),
              32'({6'b000010, 2'b00, 8'h00}));
      end
      if (!rst || !rst_prev) begin
        nv      = 0;
        nto     = 0;
        gap_exp = 1'b0;
      end else begin
        if (gap_exp) begin
          check("gap_one_cycle", 32'(valid), 32'd1);
        end
        gap_exp = 1'b0;
        if (valid) begin
          nv = nv + 1;
          if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'(exp_q.size()), 32'd1);
          end else begin
            check("data_stable", 32'(data), 32'(exp_q[0].data));
            check("retry_cnt", 32'(retry_cnt), 32'(nto));
          end
        end
        if (timeout) begin
          nto = nto + 1;
          check("timeout_exclusive", 32'({valid, done}), 32'd0);
          gap_exp = !abort;
        end
        if (abort) begin
          check("abort_with_timeout", 32'(timeout), 32'd1);
        end
        if (done) begin
          check("done_valid_low", 32'(valid), 32'd0);
        end
        if (done || abort) begin
          if (exp_q.size() == 0) begin
            check("unexpected_end", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("outcome", 32'({abort, done, 4'(nto), 8'(nv)}),
                  32'({e.ab, !e.ab, e.nto, e.nv}));
          end
          nv  = 0;
          nto = 0;
        end
      end
      rst_prev = rst;
    end
  end

endmodule
